// File: rtl/dmem_sync_if.sv
// Request/response bundle for the synchronous data memory.
// The slave side is the memory; the master side is the load/store unit.
interface dmem_sync_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_vld;
  logic              req_rdy;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_vld, req_we, req_size, req_sign, req_addr, req_wdata, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_vld, req_we, req_size, req_sign, req_addr, req_wdata, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_sync.sv
// Byte-addressed data memory with a registered read port and a single
// back-pressurable response register; bad accesses answer with rsp_err.
module dmem_sync #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic        clk,
  input logic        rst_n,
  dmem_sync_if.slave bus
);
  localparam int NB     = DATA_W / 8;
  localparam int LOG2NB = $clog2(NB);
  localparam int MW     = $clog2(DEPTH_BYTES);

  logic [7:0]        mem [DEPTH_BYTES];

  logic              acc_p0;
  logic              err_p0;
  logic [3:0]        nbytes_p0;
  logic [ADDR_W:0]   end_p0;
  logic [MW-1:0]     idx_p0;
  logic [DATA_W-1:0] raw_p0;

  logic              vld_p1;
  logic              err_p1;
  logic [DATA_W-1:0] rdata_p1;

  // Right-aligned load data is widened by an arithmetic shift pair so the
  // sign bit of the accessed field lands in every upper position.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] raw,
    input logic [1:0]        size,
    input logic              sgn
  );
    logic signed [DATA_W-1:0] shl;
    int                       pad;
    pad = ((8 << size) >= DATA_W) ? 0 : DATA_W - (8 << size);
    shl = $signed(raw << pad);
    if (sgn) return $unsigned(shl >>> pad);
    return raw;
  endfunction

  // ---- p0: request decode and memory read ----
  assign bus.req_rdy = !vld_p1 || bus.rsp_rdy;
  assign acc_p0      = bus.req_vld && bus.req_rdy;
  assign nbytes_p0   = 4'd1 << bus.req_size;
  assign idx_p0      = bus.req_addr[MW-1:0];
  assign end_p0      = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbytes_p0);

  assign err_p0 = (int'(bus.req_size) > LOG2NB)
               || ((bus.req_addr[2:0] & 3'(nbytes_p0 - 4'd1)) != 3'd0)
               || (end_p0 > (ADDR_W+1)'(DEPTH_BYTES));

  always_comb begin
    raw_p0 = '0;
    for (int k = 0; k < NB; k++) begin
      if (k < int'(nbytes_p0)) raw_p0[8*k +: 8] = mem[idx_p0 + MW'(k)];
    end
  end

  // A store coinciding with reset is dropped along with the pending response.
  always_ff @(posedge clk) begin
    if (rst_n && acc_p0 && !err_p0 && bus.req_we) begin
      for (int k = 0; k < NB; k++) begin
        if (k < int'(nbytes_p0)) mem[idx_p0 + MW'(k)] <= bus.req_wdata[8*k +: 8];
      end
    end
  end

  // ---- p1: response register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else if (acc_p0) begin
      vld_p1   <= 1'b1;
      err_p1   <= err_p0;
      rdata_p1 <= (err_p0 || bus.req_we) ? '0
                : load_extend(raw_p0, bus.req_size, bus.req_sign);
    end else if (bus.rsp_rdy) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.rsp_vld   = vld_p1;
  assign bus.rsp_err   = err_p1;
  assign bus.rsp_rdata = rdata_p1;
endmodule

// File: tb/tb_dmem_sync.sv
// Randomised and directed bench for dmem_sync against a byte-array model
// with an in-order queue of expected responses.
module tb_dmem_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic [7:0] mm [1024];
  rsp_t       exp_q [$];
  logic       chk_rst = 1'b0;

  dmem_sync_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  dmem_sync #(.DEPTH_BYTES(1024), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mm_word(input logic [31:0] a);
    return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
  endfunction

  // Reference behaviour: error rules, little-endian byte lanes, extension.
  function automatic void model_access(input logic we, input logic [1:0] size,
                                       input logic sgn, input logic [31:0] addr,
                                       input logic [31:0] wd,
                                       output logic [31:0] d, output logic e);
    int unsigned b;
    logic [63:0] v;
    b = 1 << size;
    e = (size > 2'd2) || ((addr % b) != 0) || (({32'd0, addr} + 64'(b)) > 64'd1024);
    d = '0;
    v = '0;
    if (!e) begin
      if (we) begin
        for (int k = 0; k < int'(b); k++) mm[addr+k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < int'(b); k++) v = v | (64'(mm[addr+k]) << (8*k));
        if (sgn && b < 4 && v[8*b-1]) v = v | (~64'd0 << (8*b));
        d = v[31:0];
      end
    end
  endfunction

  // Compare process: inputs are stable at the falling edge, so what is seen
  // here is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    rsp_t r;
    if (chk_rst) begin
      chk("rst_rsp_vld", 64'(bif.rsp_vld), 64'd0);
      chk("rst_rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
      chk("rst_rsp_err", 64'(bif.rsp_err), 64'd0);
      chk_rst = 1'b0;
    end
    if (bif.rsp_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", 64'(bif.rsp_vld), 64'd0);
      end else begin
        chk("rsp_rdata", 64'(bif.rsp_rdata), 64'(exp_q[0].d));
        chk("rsp_err", 64'(bif.rsp_err), 64'(exp_q[0].e));
        if (rst_n && bif.rsp_rdy) void'(exp_q.pop_front());
      end
    end
    chk("req_rdy", 64'(bif.req_rdy), 64'(!bif.rsp_vld || bif.rsp_rdy));
    if (!rst_n) begin
      exp_q.delete();
      chk_rst = 1'b1;
    end else if (bif.req_vld && bif.req_rdy) begin
      model_access(bif.req_we, bif.req_size, bif.req_sign, bif.req_addr,
                   bif.req_wdata, r.d, r.e);
      exp_q.push_back(r);
    end
  end

  task automatic set_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
    bif.req_we    = we;
    bif.req_size  = size;
    bif.req_sign  = sgn;
    bif.req_addr  = addr;
    bif.req_wdata = wd;
    bif.req_vld   = 1'b1;
  endtask

  // Presents one request until accepted; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    set_req(we, size, sgn, addr, wd);
    n = 0;
    @(negedge clk);
    while (bif.req_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bif.req_rdy !== 1'b1) chk("accept_timeout", 64'(bif.req_rdy), 64'd1);
    @(posedge clk);
    #1;
    bif.req_vld = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] d, input logic e);
    @(negedge clk);
    chk({name, "_vld"}, 64'(bif.rsp_vld), 64'd1);
    chk(name, 64'(bif.rsp_rdata), 64'(d));
    chk({name, "_err"}, 64'(bif.rsp_err), 64'(e));
  endtask

  initial begin
    logic [31:0] prior;
    logic [1:0]  sz;
    logic [31:0] ad;
    bif.req_vld = 1'b0;
    bif.req_we = 1'b0;
    bif.req_size = 2'd0;
    bif.req_sign = 1'b0;
    bif.req_addr = '0;
    bif.req_wdata = '0;
    bif.rsp_rdy = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_vld", 64'(bif.rsp_vld), 64'd0);
    chk("reset_rdata", 64'(bif.rsp_rdata), 64'd0);
    chk("reset_err", 64'(bif.rsp_err), 64'd0);
    chk("reset_req_rdy", 64'(bif.req_rdy), 64'd1);

    for (int a = 0; a < 1024; a += 4) issue(1'b1, 2'd2, 1'b0, 32'(a), $urandom);

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    expect_rsp("store_word", 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    expect_rsp("load_word", 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    expect_rsp("lb_13", 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    expect_rsp("lbu_13", 32'h000000DE, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    expect_rsp("lh_12", 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    expect_rsp("lhu_10", 32'h0000BEEF, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h5A5A5A77);
    expect_rsp("sb_11", 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    expect_rsp("lw_after_sb", 32'hDEAD77EF, 1'b0);

    issue(1'b1, 2'd2, 1'b0, 32'h3FC, 32'h01234567);
    expect_rsp("sw_3fc", 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    expect_rsp("err_misaligned_lw", 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h3FE, 32'hFFFFFFFF);
    expect_rsp("err_sw_3fe", 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hFFFFFFFF);
    expect_rsp("err_sw_400", 32'h0, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 32'h3F8, 32'hFFFFFFFF);
    expect_rsp("err_dword", 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
    expect_rsp("lw_3fc_intact", 32'h01234567, 1'b0);

    // Back-pressure: second load waits three cycles behind a stalled response.
    @(posedge clk);
    #1;
    bif.rsp_rdy = 1'b0;
    set_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("bp_first_rdy", 64'(bif.req_rdy), 64'd1);
    @(posedge clk);
    #1;
    set_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_rdy", 64'(bif.req_rdy), 64'd0);
      chk("bp_hold_rdata", 64'(bif.rsp_rdata), 64'hDEAD77EF);
      @(posedge clk);
      #1;
    end
    bif.rsp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 64'(bif.req_rdy), 64'd1);
    @(posedge clk);
    #1;
    bif.req_vld = 1'b0;
    @(negedge clk);
    chk("bp_second_rdata", 64'(bif.rsp_rdata), 64'hFFFFDEAD);

    // Reset while a response is stalled.
    @(posedge clk);
    #1;
    bif.rsp_rdy = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
    @(negedge clk);
    chk("stall_pending_vld", 64'(bif.rsp_vld), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stall_vld", 64'(bif.rsp_vld), 64'd0);

    // A store presented during reset must be dropped.
    prior = mm_word(32'h20);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bif.rsp_rdy = 1'b1;
    set_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bif.req_vld = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    expect_rsp("rst_store_dropped", prior, 1'b0);

    repeat (3000) begin
      @(posedge clk);
      #1;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = 32'($urandom_range(0, 1039));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      bif.req_vld   = ($urandom_range(0, 3) != 0);
      bif.req_we    = 1'($urandom_range(0, 1));
      bif.req_size  = sz;
      bif.req_sign  = 1'($urandom_range(0, 1));
      bif.req_addr  = ad;
      bif.req_wdata = $urandom;
      bif.rsp_rdy   = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    bif.req_vld = 1'b0;
    bif.rsp_rdy = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_rsp_vld", 64'(bif.rsp_vld), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
